// File: rtl/pwm_seq_scheduler.sv
// pwm_seq_scheduler: UART-commanded sequencer firing one PWM burst per masked channel, in ascending order.
// Optional per-burst watchdog is built when SEQ_TIMEOUT_EN is defined.
module pwm_seq_scheduler #(
  parameter int unsigned _NUM_CHANNELS = 4,
  parameter int unsigned _TO_WIDTH     = 20
) (
  input  logic                     clk_50M,
  input  logic                     rst_n,
  input  logic [7:0]               func_reg,
  input  logic [7:0]               rev_data1,
  input  logic [7:0]               rev_data2,
  input  logic [7:0]               rev_data3,
  input  logic [7:0]               rev_data4,
  input  logic                     pack_done,
  input  logic [_NUM_CHANNELS-1:0] pwm_busy,
  output logic [_NUM_CHANNELS-1:0] pwm_en,
  output logic [7:0]               cur_ch,
  output logic                     seq_busy,
  output logic                     seq_done,
  output logic                     timeout_err
);
  localparam int unsigned NCH   = _NUM_CHANNELS;
  localparam int unsigned PTR_W = 4;
  localparam logic [7:0]  FUNC_START = 8'h03;
  localparam logic [7:0]  FUNC_STOP  = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_WAIT_BUSY, S_WAIT_DONE, S_GAP, S_DONE
  } state_t;

  state_t           state, state_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [7:0]       rounds_q, rounds_d;
  logic [15:0]      gap_q, gap_d;
  logic [15:0]      gap_cnt_q, gap_cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [7:0]       cur_ch_d;
  logic [NCH-1:0]   pwm_en_d;
  logic             seq_busy_d, seq_done_d;
  logic             start_cmd, stop_cmd, busy_sel, sel_found, burst_end, to_hit;
  logic [7:0]       sel_idx;
  logic             unused_mask_hi;

  assign start_cmd      = pack_done && (func_reg == FUNC_START) && (|rev_data1[NCH-1:0]);
  assign stop_cmd       = pack_done && (func_reg == FUNC_STOP);
  assign unused_mask_hi = ^rev_data1;

  // Busy flag of the currently selected channel only.
  always_comb begin
    busy_sel = 1'b0;
    for (int i = 0; i < int'(NCH); i++)
      if (cur_ch == 8'(i)) busy_sel = pwm_busy[i];
  end

  // Lowest masked channel at or above ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--)
      if (mask_q[i] && (PTR_W'(i) >= ptr_q)) begin
        sel_found = 1'b1;
        sel_idx   = 8'(i);
      end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    mask_d    = mask_q;
    rounds_d  = rounds_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    ptr_d     = ptr_q;
    cur_ch_d  = cur_ch;
    burst_end = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_cmd) begin
          mask_d   = rev_data1[NCH-1:0];
          rounds_d = rev_data2;
          gap_d    = {rev_data3, rev_data4};
          ptr_d    = '0;
          state_d  = S_SELECT;
        end
      end
      S_SELECT: begin
        if (sel_found) begin
          cur_ch_d = sel_idx;
          state_d  = S_WAIT_BUSY;
        end else if ((rounds_q == 8'd0) || (rounds_q > 8'd1)) begin
          if (rounds_q != 8'd0) rounds_d = rounds_q - 8'd1;
          ptr_d = '0;
        end else begin
          state_d = S_DONE;
        end
      end
      S_WAIT_BUSY: begin
        if (busy_sel)    state_d   = S_WAIT_DONE;
        else if (to_hit) burst_end = 1'b1;
      end
      S_WAIT_DONE: begin
        if (!busy_sel || to_hit) burst_end = 1'b1;
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q - 16'd1;
        if (gap_cnt_q <= 16'd1) state_d = S_SELECT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (burst_end) begin
      ptr_d = PTR_W'(cur_ch) + PTR_W'(1);
      if (gap_q == 16'd0) begin
        state_d = S_SELECT;
      end else begin
        gap_cnt_d = gap_q;
        state_d   = S_GAP;
      end
    end
    // STOP overrides any transition taken in the same cycle.
    if (stop_cmd && (state != S_IDLE)) state_d = S_IDLE;
  end

  always_comb begin
    pwm_en_d = '0;
    for (int i = 0; i < int'(NCH); i++)
      pwm_en_d[i] = (state_d == S_WAIT_BUSY) && (cur_ch_d == 8'(i));
    seq_busy_d = (state_d != S_IDLE);
    seq_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      mask_q    <= '0;
      rounds_q  <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      ptr_q     <= '0;
      cur_ch    <= '0;
      pwm_en    <= '0;
      seq_busy  <= 1'b0;
      seq_done  <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      rounds_q  <= rounds_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      ptr_q     <= ptr_d;
      cur_ch    <= cur_ch_d;
      pwm_en    <= pwm_en_d;
      seq_busy  <= seq_busy_d;
      seq_done  <= seq_done_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic [_TO_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic                 timeout_err_d, in_wait;

  assign in_wait = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
  assign to_hit  = in_wait && (&to_cnt_q);

  // Counter restarts on every entry into a wait state.
  always_comb begin
    to_cnt_d = '0;
    if (in_wait && (state_d == state)) to_cnt_d = to_cnt_q + _TO_WIDTH'(1);
    timeout_err_d = timeout_err;
    if ((state == S_IDLE) && start_cmd) timeout_err_d = 1'b0;
    else if (to_hit && !stop_cmd)       timeout_err_d = 1'b1;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q    <= '0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt_q    <= to_cnt_d;
      timeout_err <= timeout_err_d;
    end
  end
`else
  // Without the watchdog the width parameter has no hardware behind it.
  logic [_TO_WIDTH-1:0] unused_to_width;
  assign unused_to_width = '0;
  assign to_hit          = 1'b0;
  assign timeout_err     = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_seq_scheduler.sv
// Directed bench for pwm_seq_scheduler with a simple PWM channel model (busy 3 cycles after enable, 20 cycles long).
// Define SEQ_TIMEOUT_EN to build the watchdog variant with a 4-bit counter.
module tb_pwm_seq_scheduler;
  localparam int unsigned NCH = 4;
`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TOW = 4;
`else
  localparam int unsigned TOW = 20;
`endif

  logic           clk_50M = 1'b0;
  logic           rst_n;
  logic [7:0]     func_reg, rev_data1, rev_data2, rev_data3, rev_data4;
  logic           pack_done;
  logic [NCH-1:0] pwm_busy;
  logic [NCH-1:0] pwm_en;
  logic [7:0]     cur_ch;
  logic           seq_busy, seq_done, timeout_err;
  logic [NCH-1:0] no_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int clr_tok  = 0;

  pwm_seq_scheduler #(._NUM_CHANNELS(NCH), ._TO_WIDTH(TOW)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .func_reg(func_reg),
    .rev_data1(rev_data1), .rev_data2(rev_data2), .rev_data3(rev_data3), .rev_data4(rev_data4),
    .pack_done(pack_done), .pwm_busy(pwm_busy), .pwm_en(pwm_en), .cur_ch(cur_ch),
    .seq_busy(seq_busy), .seq_done(seq_done), .timeout_err(timeout_err)
  );

  always #10 clk_50M = ~clk_50M;
  always @(posedge clk_50M) cyc <= cyc + 1;

  // Channel model, updated on the falling edge.
  int ph [NCH];
  always @(negedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      pwm_busy <= '0;
      for (int i = 0; i < int'(NCH); i++) ph[i] <= 0;
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        if (ph[i] == 0) begin
          if (pwm_en[i] && !no_busy[i]) ph[i] <= 1;
        end else if (ph[i] >= 22) ph[i] <= 0;
        else ph[i] <= ph[i] + 1;
        pwm_busy[i] <= (ph[i] >= 2) && (ph[i] <= 21);
      end
    end
  end

  // Event log sampled 1 time unit after each rising edge.
  int             fire_ch[$], fire_cur[$], rise_q[$], fall_q[$];
  int             done_cnt = 0, onehot_viol = 0, to_cyc = -1, seen_tok = 0;
  logic [NCH-1:0] en_prev = '0, busy_prev = '0;
  logic           to_prev = 1'b0;
  always @(posedge clk_50M) begin
    #1;
    if (seen_tok != clr_tok) begin
      seen_tok = clr_tok;
      fire_ch.delete(); fire_cur.delete(); rise_q.delete(); fall_q.delete();
      done_cnt = 0; onehot_viol = 0; to_cyc = -1;
    end
    for (int i = 0; i < int'(NCH); i++)
      if (pwm_en[i] && !en_prev[i]) begin
        fire_ch.push_back(i);
        fire_cur.push_back(int'(cur_ch));
        rise_q.push_back(cyc);
      end
    if (|(busy_prev & ~pwm_busy)) fall_q.push_back(cyc);
    if (seq_done) done_cnt++;
    if ($countones(pwm_en) > 1) onehot_viol++;
    if (timeout_err && !to_prev && (to_cyc < 0)) to_cyc = cyc;
    en_prev = pwm_en; busy_prev = pwm_busy; to_prev = timeout_err;
  end

  function automatic int fire_at(input int i);
    return (i < fire_ch.size()) ? fire_ch[i] : -1;
  endfunction
  function automatic int cur_at(input int i);
    return (i < fire_cur.size()) ? fire_cur[i] : -1;
  endfunction
  function automatic int rise_at(input int i);
    return (i < rise_q.size()) ? rise_q[i] : -1;
  endfunction
  function automatic int fall_at(input int i);
    return (i < fall_q.size()) ? fall_q[i] : -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    clr_tok++;
    @(posedge clk_50M); #2;
  endtask

  task automatic send_cmd(input logic [7:0] fc, input logic [7:0] d1, input logic [7:0] d2,
                          input logic [15:0] gap);
    @(negedge clk_50M);
    func_reg = fc; rev_data1 = d1; rev_data2 = d2; {rev_data3, rev_data4} = gap; pack_done = 1'b1;
    @(negedge clk_50M);
    pack_done = 1'b0; func_reg = 8'h00;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (seq_busy && (n < budget)) begin @(negedge clk_50M); n++; end
    check(tag, 32'(seq_busy), 32'd0);
  endtask

  task automatic wait_bursts(input string tag, input int cnt, input int budget);
    int n = 0;
    while ((fire_ch.size() < cnt) && (n < budget)) begin @(negedge clk_50M); n++; end
    check(tag, 32'(fire_ch.size() >= cnt), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got=hang expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; func_reg = '0; rev_data1 = '0; rev_data2 = '0; rev_data3 = '0; rev_data4 = '0;
    pack_done = 1'b0; no_busy = '0;
    repeat (3) @(negedge clk_50M);
    check("rst_pwm_en", 32'(pwm_en), 32'd0);
    check("rst_cur_ch", 32'(cur_ch), 32'd0);
    check("rst_seq_busy", 32'(seq_busy), 32'd0);
    check("rst_seq_done", 32'(seq_done), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50M);

    // Mask 0x05, one round, gap 10.
    clear_log();
    send_cmd(8'h03, 8'h05, 8'd1, 16'd10);
    check("t1_busy_after_start", 32'(seq_busy), 32'd1);
    wait_idle("t1_idle", 400);
    check("t1_bursts", 32'(fire_ch.size()), 32'd2);
    check("t1_first_ch", 32'(fire_at(0)), 32'd0);
    check("t1_second_ch", 32'(fire_at(1)), 32'd2);
    check("t1_cur_ch0", 32'(cur_at(0)), 32'd0);
    check("t1_cur_ch1", 32'(cur_at(1)), 32'd2);
    check("t1_gap_latency", 32'(rise_at(1) - fall_at(0)), 32'd11);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    repeat (10) @(negedge clk_50M);

    // Mask 0x0F, three rounds, no gap.
    clear_log();
    send_cmd(8'h03, 8'h0F, 8'd3, 16'd0);
    wait_idle("t2_idle", 1000);
    check("t2_bursts", 32'(fire_ch.size()), 32'd12);
    for (int i = 0; i < 12; i++) check($sformatf("t2_order_%0d", i), 32'(fire_at(i)), 32'(i % 4));
    check("t2_onehot", 32'(onehot_viol), 32'd0);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);
    repeat (10) @(negedge clk_50M);

    // Continuous mask 0x02, STOP during the 5th burst.
    clear_log();
    send_cmd(8'h03, 8'h02, 8'd0, 16'd0);
    wait_bursts("t3_reach_5", 5, 600);
    repeat (5) @(negedge clk_50M);
    send_cmd(8'h04, 8'h00, 8'd0, 16'd0);
    check("t3_stop_pwm_en", 32'(pwm_en), 32'd0);
    check("t3_stop_seq_busy", 32'(seq_busy), 32'd0);
    repeat (40) @(negedge clk_50M);
    check("t3_no_more_bursts", 32'(fire_ch.size()), 32'd5);
    check("t3_fifth_ch", 32'(fire_at(4)), 32'd1);
    check("t3_no_done", 32'(done_cnt), 32'd0);

    // START while busy, then START with an empty effective mask.
    clear_log();
    send_cmd(8'h03, 8'h01, 8'd2, 16'd0);
    wait_bursts("t4_first", 1, 100);
    send_cmd(8'h03, 8'h0F, 8'd1, 16'd0);
    check("t4_cur_ch_kept", 32'(cur_ch), 32'd0);
    check("t4_still_busy", 32'(seq_busy), 32'd1);
    wait_idle("t4_idle", 400);
    check("t4_bursts", 32'(fire_ch.size()), 32'd2);
    check("t4_second_ch", 32'(fire_at(1)), 32'd0);
    check("t4_done_cnt", 32'(done_cnt), 32'd1);
    clear_log();
    send_cmd(8'h03, 8'hF0, 8'd1, 16'd0);
    send_cmd(8'h03, 8'h00, 8'd1, 16'd0);
    repeat (10) @(negedge clk_50M);
    check("t4_zero_mask_idle", 32'(seq_busy), 32'd0);
    check("t4_zero_mask_bursts", 32'(fire_ch.size()), 32'd0);

`ifdef SEQ_TIMEOUT_EN
    // Channel 0 never answers; the watchdog must release it.
    clear_log();
    no_busy = 4'b0001;
    send_cmd(8'h03, 8'h03, 8'd1, 16'd0);
    wait_idle("t5_idle", 400);
    check("t5_timeout_err", 32'(timeout_err), 32'd1);
    check("t5_to_latency", 32'(((to_cyc - rise_at(0)) >= 15) && ((to_cyc - rise_at(0)) <= 17)), 32'd1);
    check("t5_ch1_fired", 32'(fire_at(1)), 32'd1);
    check("t5_done_cnt", 32'(done_cnt), 32'd1);
    no_busy = '0;
    repeat (5) @(negedge clk_50M);
    send_cmd(8'h03, 8'h01, 8'd1, 16'd0);
    check("t5_start_clears", 32'(timeout_err), 32'd0);
    wait_idle("t5_idle2", 400);
`else
    check("t5_timeout_tied", 32'(timeout_err), 32'd0);
`endif
    repeat (10) @(negedge clk_50M);

    // Asynchronous reset in the middle of a long gap.
    clear_log();
    send_cmd(8'h03, 8'h06, 8'd1, 16'd1000);
    begin
      int n = 0;
      while ((fall_q.size() < 1) && (n < 200)) begin @(negedge clk_50M); n++; end
    end
    check("t6_first_fall", 32'(fall_q.size()), 32'd1);
    repeat (3) @(negedge clk_50M);
    check("t6_pre_cur_ch", 32'(cur_ch), 32'd1);
    check("t6_pre_busy", 32'(seq_busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_pwm_en", 32'(pwm_en), 32'd0);
    check("t6_rst_cur_ch", 32'(cur_ch), 32'd0);
    check("t6_rst_seq_busy", 32'(seq_busy), 32'd0);
    check("t6_rst_seq_done", 32'(seq_done), 32'd0);
    check("t6_rst_timeout", 32'(timeout_err), 32'd0);
    repeat (2) @(negedge clk_50M);
    rst_n = 1'b1;
    repeat (30) @(negedge clk_50M);
    check("t6_post_idle", 32'(seq_busy), 32'd0);
    check("t6_post_pwm_en", 32'(pwm_en), 32'd0);
    check("t6_post_bursts", 32'(fire_ch.size()), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
